// File: rtl/axi_write.sv
// AXI4 write master: packs an AXI-Stream into fixed-length INCR bursts written
// at a frame-stride address, pulsing o_wr_done after each write response.
module axi_write #(
  parameter int unsigned AW_FLIP_BYTE  = 0,
  parameter int unsigned AW_ADDR_WIDTH = 32,
  parameter int unsigned AW_DATA_WIDTH = 64,
  parameter int unsigned AW_LEN        = 16,
  parameter int unsigned AW_STRIDE     = 1024,
  parameter int unsigned AW_FRAMES     = 64
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_areset,
  input  logic [AW_DATA_WIDTH-1:0]   S_WR_tdata,
  input  logic                       S_WR_tvalid,
  output logic                       S_WR_tready,
  input  logic                       S_WR_tlast,
  output logic                       o_wr_done,
  output logic                       o_wr_err,
  output logic                       m_axi_awid,
  output logic [AW_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic [3:0]                 m_axi_awqos,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [AW_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AW_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic                       m_axi_bid,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready
);

  localparam int unsigned NB = AW_DATA_WIDTH / 8;
  localparam logic [AW_ADDR_WIDTH-1:0] STRIDE    = AW_ADDR_WIDTH'(AW_STRIDE);
  localparam logic [AW_ADDR_WIDTH-1:0] LAST_BASE = AW_ADDR_WIDTH'(AW_STRIDE * (AW_FRAMES - 1));
  localparam logic [8:0]               LAST_BEAT = 9'(AW_LEN - 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, WR_DONE} state_t;

  state_t                   state, state_n;
  logic [8:0]               beat_cnt;
  logic [AW_ADDR_WIDTH-1:0] base;
  logic                     awvalid_q;
  logic                     err_q;
  logic                     last_beat;
  logic                     beat_xfer;
  logic [AW_DATA_WIDTH-1:0] data_fmt;
  logic                     unused_ok;

  assign unused_ok = &{1'b0, m_axi_bid};

  assign m_axi_awid    = 1'b0;
  assign m_axi_awaddr  = base;
  assign m_axi_awlen   = 8'(AW_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(NB));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd3;
  assign m_axi_awprot  = '0;
  assign m_axi_awqos   = '0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = data_fmt;
  assign o_wr_err      = err_q;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign beat_xfer = (state == WR_DATA) && S_WR_tvalid && m_axi_wready;

  always_comb begin
    data_fmt = S_WR_tdata;
    if (AW_FLIP_BYTE != 0) begin
      for (int unsigned i = 0; i < NB; i++) begin
        data_fmt[8*i +: 8] = S_WR_tdata[8*(NB-1-i) +: 8];
      end
    end
  end

  always_comb begin
    state_n      = state;
    m_axi_wvalid = 1'b0;
    m_axi_wlast  = 1'b0;
    m_axi_bready = 1'b0;
    S_WR_tready  = 1'b0;
    o_wr_done    = 1'b0;
    case (state)
      IDLE:    if (S_WR_tvalid) state_n = WR_ADDR;
      WR_ADDR: if (m_axi_awready) state_n = WR_DATA;
      WR_DATA: begin
        // W channel is a straight pass-through of the stream
        m_axi_wvalid = S_WR_tvalid;
        S_WR_tready  = m_axi_wready;
        m_axi_wlast  = last_beat;
        if (beat_xfer && last_beat) state_n = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_n = WR_DONE;
      end
      WR_DONE: begin
        o_wr_done = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state     <= IDLE;
      awvalid_q <= 1'b0;
      beat_cnt  <= '0;
      base      <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      // registered AWVALID: high for exactly the cycles spent in WR_ADDR
      awvalid_q <= (state_n == WR_ADDR);
      if (beat_xfer) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 9'd1;
        if (S_WR_tlast != last_beat) err_q <= 1'b1;
      end
      if (state == WR_RESP && m_axi_bvalid && m_axi_bresp != 2'b00) err_q <= 1'b1;
      if (state == WR_DONE) base <= (base >= LAST_BASE) ? '0 : base + STRIDE;
    end
  end

endmodule

// File: tb/tb_axi_write.sv
// Directed bench for axi_write: table of burst scenarios plus hand-written
// address-wrap and mid-burst reset sequences; a second instance checks byte flip.
module tb_axi_write;

  localparam int LEN = 16;

  logic        clk = 1'b0;
  logic        areset;
  logic [63:0] tdata;
  logic        tvalid, tlast, awready, wready, bvalid;
  logic [1:0]  bresp;

  logic        tready, done, err, awid, awlock, awvalid, wlast, wvalid, bready;
  logic [31:0] awaddr;
  logic [7:0]  awlen, wstrb;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos;
  logic [63:0] wdata;

  logic        f_tready, f_done, f_err, f_awid, f_awlock, f_awvalid, f_wlast, f_wvalid, f_bready;
  logic [31:0] f_awaddr;
  logic [7:0]  f_awlen, f_wstrb;
  logic [2:0]  f_awsize, f_awprot;
  logic [1:0]  f_awburst;
  logic [3:0]  f_awcache, f_awqos;
  logic [63:0] f_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_write #(.AW_FLIP_BYTE(0), .AW_ADDR_WIDTH(32), .AW_DATA_WIDTH(64), .AW_LEN(LEN),
              .AW_STRIDE(1024), .AW_FRAMES(64)) dut (
    .m_axi_aclk(clk), .m_axi_areset(areset),
    .S_WR_tdata(tdata), .S_WR_tvalid(tvalid), .S_WR_tready(tready), .S_WR_tlast(tlast),
    .o_wr_done(done), .o_wr_err(err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(1'b0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready));

  axi_write #(.AW_FLIP_BYTE(1), .AW_ADDR_WIDTH(32), .AW_DATA_WIDTH(64), .AW_LEN(LEN),
              .AW_STRIDE(1024), .AW_FRAMES(64)) dut_f (
    .m_axi_aclk(clk), .m_axi_areset(areset),
    .S_WR_tdata(tdata), .S_WR_tvalid(tvalid), .S_WR_tready(f_tready), .S_WR_tlast(tlast),
    .o_wr_done(f_done), .o_wr_err(f_err),
    .m_axi_awid(f_awid), .m_axi_awaddr(f_awaddr), .m_axi_awlen(f_awlen), .m_axi_awsize(f_awsize),
    .m_axi_awburst(f_awburst), .m_axi_awlock(f_awlock), .m_axi_awcache(f_awcache),
    .m_axi_awprot(f_awprot), .m_axi_awqos(f_awqos), .m_axi_awvalid(f_awvalid),
    .m_axi_awready(awready), .m_axi_wdata(f_wdata), .m_axi_wstrb(f_wstrb), .m_axi_wlast(f_wlast),
    .m_axi_wvalid(f_wvalid), .m_axi_wready(wready), .m_axi_bid(1'b0), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(f_bready));

  typedef struct {
    logic [31:0] addr;
    bit          tv_gap;
    bit          wr_gap;
    int          tlast_at;
    logic [1:0]  resp;
    bit          early_b;
    bit          pre_reset;
    bit          exp_err;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] word(input int tag, input int beat);
    if (tag == 2) return 64'h0011223344556677;
    return {32'(tag), 32'(beat)};
  endfunction

  function automatic logic [63:0] rev64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

  task automatic do_reset();
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_awvalid"}, awvalid, 0);
    chk({nm, "_wvalid"}, wvalid, 0);
    chk({nm, "_wlast"}, wlast, 0);
    chk({nm, "_bready"}, bready, 0);
    chk({nm, "_tready"}, tready, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_awaddr"}, awaddr, 0);
  endtask

  // Caller is at posedge+1 with the DUT in IDLE; returns at posedge+1.
  task automatic run_burst(input vec_t v, input int tag, input int abort_at);
    int beat = 0;
    int cyc = 0;
    bit ok = 0;
    logic [63:0] d, expf;
    if (v.pre_reset) do_reset();
    tvalid = 1'b1; tdata = word(tag, 0); tlast = (v.tlast_at == 0);
    #3 chk("idle_tready", tready, 0);
    chk("idle_awvalid", awvalid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 10 && !ok; i++) begin
      #3;
      if (awvalid) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL aw_timeout: got no awvalid expected awvalid within 10 cycles");
      return;
    end
    chk("awaddr", awaddr, v.addr);
    chk("awlen", awlen, 8'h0F);
    if (v.tv_gap) begin
      @(posedge clk); #4;
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_hold", awaddr, v.addr);
    end
    awready = 1'b1;
    @(posedge clk); #1 awready = 1'b0;
    while (beat < LEN && cyc < 200) begin
      if (beat == abort_at) begin
        #3 chk("err_before_abort", err, 1);
        areset = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("abort");
        areset = 1'b0; tvalid = 1'b0; wready = 1'b0;
        @(posedge clk); #1;
        return;
      end
      tvalid = !(v.tv_gap && (cyc % 3 == 1));
      wready = !(v.wr_gap && (cyc % 4 == 2));
      d = word(tag, beat); tdata = d; tlast = (beat == v.tlast_at);
      bvalid = v.early_b && (beat == LEN - 1); bresp = v.resp;
      #3;
      chk("wvalid", wvalid, tvalid);
      chk("wlast", wlast, beat == LEN - 1);
      if (wvalid) begin
        chk("wdata", wdata, d);
        expf = (tag == 2) ? 64'h7766554433221100 : rev64(d);
        chk("wdata_flip", f_wdata, expf);
        chk("tready", tready, wready);
      end
      if (bvalid) chk("bready_in_data", bready, 0);
      if (wvalid && wready) beat++;
      @(posedge clk); #1; cyc++;
    end
    if (beat != LEN) begin
      n_tests++; n_fail++;
      $display("FAIL w_timeout: got %0d beats expected %0d", beat, LEN);
      return;
    end
    tvalid = 1'b0; wready = 1'b1; bresp = v.resp;
    if (!v.early_b) begin
      bvalid = 1'b0;
      #3 chk("resp_wait_bready", bready, 1);
      chk("resp_wait_done", done, 0);
      @(posedge clk); #1 bvalid = 1'b1;
    end
    #3 chk("bready", bready, 1);
    chk("resp_tready", tready, 0);
    @(posedge clk); #1 bvalid = 1'b0;
    #3 chk("done_pulse", done, 1);
    chk("err", err, v.exp_err);
    @(posedge clk); #4 chk("done_drop", done, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{32'h0000, 0, 0, 15, 2'b00, 0, 0, 0};
    tbl[1] = '{32'h0400, 1, 1, 15, 2'b00, 0, 0, 0};
    tbl[2] = '{32'h0800, 1, 0, 15, 2'b00, 1, 0, 0};
    tbl[3] = '{32'h0000, 0, 0,  7, 2'b00, 0, 1, 1};
    tbl[4] = '{32'h0000, 0, 1, 15, 2'b10, 0, 1, 1};

    do_reset();
    #3;
    chk_idle_outputs("rst");
    chk("awsize", awsize, 3);
    chk("awburst", awburst, 1);
    chk("awcache", awcache, 3);
    chk("wstrb", wstrb, 8'hFF);
    chk("awid", awid, 0);
    chk("awlock", awlock, 0);
    chk("awprot", awprot, 0);
    chk("awqos", awqos, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_burst(tbl[i], i, -1);

    do_reset();
    for (int i = 0; i < 65; i++) begin
      v = '{(i < 64) ? 32'(i * 1024) : 32'h0, 0, 0, 15, 2'b00, 0, 0, 0};
      run_burst(v, 100 + i, -1);
    end

    v = '{32'h0400, 0, 0, 2, 2'b00, 0, 0, 1};
    run_burst(v, 300, 5);
    v = '{32'h0000, 0, 0, 15, 2'b00, 0, 0, 0};
    run_burst(v, 301, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_write.md
Name: axi_write

Overview:
AXI4 write master. It takes an AXI-Stream of pixel/sample words, packs them into fixed-length INCR bursts and writes them to DDR at a frame-stride address. It pulses o_wr_done after each burst's write response. This block is the producer-side counterpart of the burst read path, and o_wr_done drives that reader's i_wr_done.

Parameters:
AW_FLIP_BYTE, 0, 1 = byte-reverse each stream word before it goes onto WDATA; 0 = pass through.
AW_ADDR_WIDTH, 32, AXI address width.
AW_DATA_WIDTH, 64, data width; legal values are 32, 64 and 128.
AW_LEN, 16, beats per burst; range 1-256.
AW_STRIDE, 1024, byte increment between consecutive bursts.
AW_FRAMES, 64, number of burst slots before the address wraps to 0.

Ports:
m_axi_aclk  in  1  single clock for the whole block.
m_axi_areset  in  1  reset; synchronous, active-high.
S_WR_tdata  in  AW_DATA_WIDTH  stream data.
S_WR_tvalid  in  1  stream valid.
S_WR_tready  out  1  stream ready.
S_WR_tlast  in  1  marks the last beat of a burst-sized packet.
o_wr_done  out  1  one-cycle pulse when a burst completes.
o_wr_err  out  1  sticky error flag; cleared only by reset.
m_axi_awid  out  1  constant 0.
m_axi_awaddr  out  AW_ADDR_WIDTH  burst address.
m_axi_awlen  out  8  constant AW_LEN-1.
m_axi_awsize  out  3  clogb2(AW_DATA_WIDTH/8-1).
m_axi_awburst  out  2  constant 2'b01 (INCR).
m_axi_awlock  out  1  constant 0.
m_axi_awcache  out  4  constant 4'd3.
m_axi_awprot  out  3  constant 0.
m_axi_awqos  out  4  constant 0.
m_axi_awvalid  out  1  address valid.
m_axi_awready  in  1  address ready.
m_axi_wdata  out  AW_DATA_WIDTH  write data.
m_axi_wstrb  out  AW_DATA_WIDTH/8  all ones.
m_axi_wlast  out  1  last beat of the burst.
m_axi_wvalid  out  1  write data valid.
m_axi_wready  in  1  write data ready.
m_axi_bid  in  1  ignored.
m_axi_bresp  in  2  write response.
m_axi_bvalid  in  1  response valid.
m_axi_bready  out  1  response ready.

Behaviour:
- Reset: state=IDLE; awvalid, wvalid, wlast, bready, S_WR_tready, o_wr_done and o_wr_err are all 0; the address base register is 0.
- A reset asserted mid-burst aborts the burst. All outputs return to reset values on the next edge, so the interconnect must be reset in the same cycle.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, WR_DONE.
- IDLE -> WR_ADDR when S_WR_tvalid=1. No data is consumed in IDLE.
- WR_ADDR: awvalid=1 and awaddr=base are registered. awvalid stays high until awready is sampled high, then the FSM moves to WR_DATA. awvalid must not drop before that handshake.
- WR_DATA: combinational pass-through.
  - wvalid = S_WR_tvalid.
  - S_WR_tready = m_axi_wready.
  - wdata = S_WR_tdata, byte-flipped if AW_FLIP_BYTE=1; the flip swaps byte i with byte N-1-i across the full width.
  - A beat transfers when wvalid and wready are both 1; each beat increments beat_cnt.
  - wlast = (beat_cnt == AW_LEN-1) and is held stable while stalled.
  - On the beat with wlast, the FSM moves to WR_RESP and beat_cnt is cleared.
- Zero added latency on W: WDATA reflects the current stream word in the same cycle.
- tlast check, per transferred beat:
  - S_WR_tlast=1 on a beat that is not last, or S_WR_tlast=0 on the last beat, sets o_wr_err.
  - The burst still completes with exactly AW_LEN beats.
- WR_RESP: bready=1 and S_WR_tready=0. On bvalid the FSM moves to WR_DONE. bresp != 2'b00 sets o_wr_err.
- WR_DONE (1 cycle):
  - o_wr_done=1.
  - base <= (base >= AW_STRIDE*(AW_FRAMES-1)) ? 0 : base+AW_STRIDE.
  - Next state is IDLE.
- No overlap: at most one outstanding burst; a new AW is never issued before the B handshake.
- If bvalid arrives in the same cycle as the last W beat, it is not accepted, because bready is 0 in WR_DATA. It is accepted in WR_RESP on the next cycle, because the slave holds bvalid.
- A stream stall (tvalid=0) in WR_DATA drops wvalid; beat_cnt and wlast hold.

Test Plan:
- Reset, then AW_LEN=16 with 16 continuous beats of 0x0..0xF, awready=1, wready=1, bresp=0:
  - awaddr = 0x0 and awlen = 0x0F.
  - wlast is high on beat 15 only.
  - o_wr_done pulses once; the next awaddr is 0x400.
- Random gaps in tvalid and wready:
  - All 16 beats arrive in order with no duplicates.
  - wdata and wlast stay stable while wready=0.
- Run 64 bursts back-to-back:
  - Addresses go 0x0, 0x400, ..., 0xFC00.
  - The 65th burst uses 0x0.
- AW_FLIP_BYTE=1, AW_DATA_WIDTH=64, input 0x0011223344556677 -> wdata 0x7766554433221100.
- Error cases:
  - bresp=2'b10 -> o_wr_err=1 and o_wr_done still pulses.
  - A separate run with S_WR_tlast on beat 7 -> o_wr_err=1 and the burst still issues 16 beats.
- Assert m_axi_areset on beat 5 of a burst:
  - All outputs are 0 on the next edge and o_wr_err is cleared.
  - The next burst starts at awaddr 0x0.
